// File: rtl/csr_rmw_sequencer.sv
// CSR read-modify-write sequencer: reads the old CSR value, optionally writes the
// modified value back, stalls EX while busy and flags NAK/timeout as illegal.
module csr_rmw_sequencer #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            start,
  input  logic            csr_swap,
  input  logic            csr_set,
  input  logic            csr_clr,
  input  logic            csr_imm,
  input  logic [11:0]     csr_addr,
  input  logic [4:0]      zimm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            rs1_zero,
  input  logic            flush,
  output logic            csr_req,
  output logic            csr_we,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            csr_ack,
  input  logic            csr_nak,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rd_wdata,
  output logic            illegal
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, FAULT} state_t;
  typedef enum logic [1:0] {OP_SWAP, OP_SET, OP_CLR} op_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  op_t             op_q;
  logic [XLEN-1:0] operand_q;
  logic            wr_need_q;
  logic            req_d, we_d, done_d, illegal_d;
  logic            has_op_c, busy_c, timeout_c, rd_latch_c;
  logic [XLEN-1:0] new_val_c;

  assign has_op_c   = csr_swap | csr_set | csr_clr;
  assign busy_c     = (state_q == READ) || (state_q == WRITE);
  assign timeout_c  = !csr_ack && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign rd_latch_c = (state_q == READ) && csr_ack && !csr_nak && !flush;
  assign stall      = ((state_q == IDLE) && start) || busy_c;

  // Modified value is formed from the read data as it is acked
  always_comb begin
    new_val_c = operand_q;
    case (op_q)
      OP_SET:  new_val_c = csr_rdata | operand_q;
      OP_CLR:  new_val_c = csr_rdata & ~operand_q;
      default: new_val_c = operand_q;
    endcase
  end

  // State register and per-phase ack timeout counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (busy_c && !csr_ack) cnt_q <= cnt_q + CW'(1);
    end
  end

  // Next-state logic; flush aborts a read but never a write
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && !flush) state_d = has_op_c ? READ : FAULT;
      end
      READ: begin
        if (flush)          state_d = IDLE;
        else if (csr_ack)   state_d = csr_nak ? FAULT : (wr_need_q ? WRITE : DONE);
        else if (timeout_c) state_d = FAULT;
      end
      WRITE: begin
        if (csr_ack)        state_d = csr_nak ? FAULT : DONE;
        else if (timeout_c) state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the upcoming state
  always_comb begin
    req_d     = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_d)
      READ:    req_d = 1'b1;
      WRITE: begin
        req_d = 1'b1;
        we_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      FAULT:   illegal_d = 1'b1;
      default: req_d = 1'b0;
    endcase
  end

  // Registered outputs and captured instruction fields
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      csr_req    <= 1'b0;
      csr_we     <= 1'b0;
      done       <= 1'b0;
      illegal    <= 1'b0;
      csr_addr_o <= '0;
      csr_wdata  <= '0;
      rd_wdata   <= '0;
      op_q       <= OP_SWAP;
      operand_q  <= '0;
      wr_need_q  <= 1'b0;
    end else begin
      csr_req <= req_d;
      csr_we  <= we_d;
      done    <= done_d;
      illegal <= illegal_d;
      if ((state_q == IDLE) && start) begin
        csr_addr_o <= csr_addr;
        op_q       <= csr_swap ? OP_SWAP : (csr_set ? OP_SET : OP_CLR);
        operand_q  <= csr_imm ? XLEN'(zimm) : rs1_data;
        wr_need_q  <= csr_swap || !(csr_imm ? (zimm == 5'd0) : rs1_zero);
      end
      if (rd_latch_c) begin
        rd_wdata  <= csr_rdata;
        csr_wdata <= new_val_c;
      end
    end
  end

endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Scoreboard bench for csr_rmw_sequencer: a CSR-file responder, a result monitor
// and a driver that predicts each transaction's outcome from the instruction rules.
module tb_csr_rmw_sequencer;
  localparam int T     = 16;
  localparam int NOACK = 1000;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        start = 0, csr_swap = 0, csr_set = 0, csr_clr = 0, csr_imm = 0;
  logic [11:0] csr_addr = '0;
  logic [4:0]  zimm = '0;
  logic [31:0] rs1_data = '0;
  logic        rs1_zero = 0, flush = 0;
  logic        csr_req, csr_we, stall, done, illegal;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_wdata, rd_wdata;
  logic [31:0] csr_rdata = '0;
  logic        csr_ack = 0, csr_nak = 0;

  csr_rmw_sequencer #(.XLEN(32), .TIMEOUT_CYC(T)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .csr_swap(csr_swap), .csr_set(csr_set),
    .csr_clr(csr_clr), .csr_imm(csr_imm), .csr_addr(csr_addr), .zimm(zimm),
    .rs1_data(rs1_data), .rs1_zero(rs1_zero), .flush(flush), .csr_req(csr_req),
    .csr_we(csr_we), .csr_addr_o(csr_addr_o), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ack(csr_ack), .csr_nak(csr_nak), .stall(stall),
    .done(done), .rd_wdata(rd_wdata), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { bit is_fault; logic [31:0] rd; int lat; int start_cyc; } exp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];

  int n_tests = 0, n_fail = 0;
  logic [31:0] cur_rd = '0;
  int rsp_rdly = 0, rsp_wdly = 0;
  bit rsp_rnak = 0, rsp_wnak = 0;
  logic [31:0] rsp_old = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CSR file model: acks each phase after its configured delay
  initial begin : responder
    bit   prev_req = 0, prev_we = 0;
    int   pc = 0;
    wr_t  cur_w = '{addr: '0, data: '0};
    forever begin
      @(negedge CLK);
      csr_ack   = 0;
      csr_nak   = 0;
      csr_rdata = $urandom;
      if (!nRST) begin
        prev_req = 0;
        continue;
      end
      if (csr_req) begin
        if (!prev_req || csr_we != prev_we) begin
          pc = 0;
          if (csr_we) begin
            if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
            else cur_w = wr_q.pop_front();
          end
        end else pc++;
        if (csr_we) begin
          check("write_addr", 32'(csr_addr_o), 32'(cur_w.addr));
          check("write_data", csr_wdata, cur_w.data);
        end
        if (pc == (csr_we ? rsp_wdly : rsp_rdly)) begin
          csr_ack = 1;
          csr_nak = csr_we ? rsp_wnak : rsp_rnak;
          if (!csr_we) csr_rdata = rsp_old;
        end
      end
      prev_req = csr_req;
      prev_we  = csr_we;
    end
  end

  // Result monitor: every done/illegal pulse must match the oldest prediction
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (nRST && (done || illegal)) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("illegal", 32'(illegal), 32'(e.is_fault));
          check("done", 32'(done), 32'(!e.is_fault));
          check("rd_wdata", rd_wdata, e.rd);
          check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          check("stall_at_end", 32'(stall), 32'd0);
        end
      end
    end
  end

  // mode: 0 plain, 1 flush in first read cycle, 2 flush in write, 3 reset in write
  task automatic do_txn(input bit sw, input bit st, input bit cl, input bit imm,
                        input logic [4:0] z, input logic [31:0] rs1, input bit r0,
                        input logic [11:0] addr, input logic [31:0] old,
                        input int rdly, input int wdly, input bit rnak, input bit wnak,
                        input int mode_in);
    int mode = mode_in, w, waited;
    bit has_op, skip, flushed, finished;
    logic [31:0] operand, nv;
    exp_t e;
    has_op  = sw | st | cl;
    operand = imm ? {27'b0, z} : rs1;
    skip    = !sw && (imm ? (z == 5'd0) : r0);
    nv      = sw ? operand : (st ? (old | operand) : (old & ~operand));
    if (!has_op) mode = 0;
    if (mode == 1 && rdly < 1) rdly = 1;
    if ((mode == 2 || mode == 3) && (rdly >= T || rnak || skip)) mode = 0;
    e = '{is_fault: 1'b1, rd: cur_rd, lat: 1, start_cyc: 0};
    if (has_op && mode != 1) begin
      if (rdly >= T) e.lat = 1 + T;
      else if (rnak) e.lat = 2 + rdly;
      else begin
        cur_rd = old;
        e.rd   = old;
        if (skip) begin e.is_fault = 0; e.lat = 2 + rdly; end
        else begin
          w = 2 + rdly;
          wr_q.push_back('{addr: addr, data: nv});
          if (wdly >= T) e.lat = w + T;
          else if (wnak) e.lat = w + wdly + 1;
          else begin e.is_fault = 0; e.lat = w + wdly + 1; end
        end
      end
    end
    rsp_rdly = rdly; rsp_wdly = wdly; rsp_rnak = rnak; rsp_wnak = wnak; rsp_old = old;
    @(negedge CLK);
    start = 1; csr_swap = sw; csr_set = st; csr_clr = cl; csr_imm = imm; zimm = z;
    rs1_data = rs1; rs1_zero = r0; csr_addr = addr;
    e.start_cyc = cyc;
    if (mode != 1 && mode != 3) exp_q.push_back(e);
    #1 check("stall_on_start", 32'(stall), 32'd1);
    @(negedge CLK);
    start = 0; csr_swap = $urandom; csr_set = $urandom; csr_clr = $urandom;
    rs1_data = $urandom; csr_addr = 12'($urandom);
    if (mode == 1) begin
      flush = 1;
      @(negedge CLK);
      flush = 0;
      check("abort_stall", 32'(stall), 32'd0);
      check("abort_req", 32'(csr_req), 32'd0);
      repeat (2) @(negedge CLK);
      return;
    end
    flushed  = 0;
    finished = 0;
    for (waited = 0; waited < 100; waited++) begin
      if (done || illegal) begin finished = 1; break; end
      check("stall_busy", 32'(stall), 32'd1);
      if (mode == 3 && csr_we) begin
        nRST = 0;
        #1;
        check("rst_req", 32'(csr_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_we", 32'(csr_we), 32'd0);
        check("rst_rd", rd_wdata, 32'd0);
        cur_rd = '0;
        @(negedge CLK);
        nRST = 1;
        finished = 1;
        break;
      end
      flush = (mode == 2 && csr_we && !flushed);
      if (flush) flushed = 1;
      @(negedge CLK);
    end
    flush = 0;
    if (!finished) check("completion_timeout", 32'd1, 32'd0);
    @(negedge CLK);
  endtask

  initial begin : driver
    int ops, mode, rd_d, wr_d;
    bit r0;
    logic [4:0] z;
    repeat (3) @(negedge CLK);
    check("reset_req", 32'(csr_req), 32'd0);
    check("reset_we", 32'(csr_we), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_rd", rd_wdata, 32'd0);
    nRST = 1;
    @(negedge CLK);
    // CSRRS x5=0xF0 over 0x0F; read-only CSRRCI; delayed CSRRW; naks; flushes; timeouts
    do_txn(0,1,0,0, 5'd0, 32'h0000_00F0, 0, 12'h300, 32'h0000_000F, 0,0, 0,0, 0);
    do_txn(0,0,1,1, 5'd0, 32'hFFFF_FFFF, 0, 12'h341, 32'h1234_5678, 0,0, 0,0, 0);
    do_txn(1,0,0,0, 5'd0, 32'hDEAD_BEEF, 0, 12'h305, 32'hCAFE_0000, 3,3, 0,0, 0);
    do_txn(1,0,0,0, 5'd0, 32'h1111_1111, 0, 12'hFFF, 32'h2222_2222, 1,0, 1,0, 0);
    do_txn(0,1,0,1, 5'd7, 32'h0,         0, 12'h300, 32'h8000_0000, 2,0, 0,0, 1);
    do_txn(1,0,0,1, 5'd9, 32'h0,         0, 12'h340, 32'h5555_5555, 0,2, 0,0, 2);
    do_txn(0,0,1,0, 5'd0, 32'h0000_FFFF, 0, 12'h344, 32'hABCD_EF01, NOACK,0, 0,0, 0);
    do_txn(0,0,1,0, 5'd0, 32'h0000_FFFF, 0, 12'h344, 32'hABCD_EF01, 0,NOACK, 0,0, 0);
    do_txn(0,0,0,0, 5'd3, 32'h1,         0, 12'h300, 32'h0,         0,0, 0,0, 0);
    do_txn(1,1,1,0, 5'd0, 32'h0F0F_0F0F, 0, 12'h304, 32'hF0F0_0000, 0,1, 0,0, 0);
    do_txn(0,1,0,0, 5'd0, 32'h0,         1, 12'h300, 32'h7777_0000, 0,0, 0,0, 0);
    do_txn(0,0,1,1, 5'd31,32'h0,         0, 12'h300, 32'hFFFF_FFFF, 0,0, 0,1, 0);
    for (int i = 0; i < 160; i++) begin
      ops  = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 7);
      r0   = ($urandom_range(0, 3) == 0);
      z    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd_d = ($urandom_range(0, 19) == 0) ? NOACK : $urandom_range(0, 4);
      wr_d = ($urandom_range(0, 19) == 0) ? NOACK : $urandom_range(0, 4);
      mode = $urandom_range(0, 9);
      mode = (mode == 0) ? 1 : ((mode == 1) ? 2 : 0);
      do_txn(ops[0], ops[1], ops[2], 1'($urandom), z, r0 ? 32'h0 : $urandom, r0,
             12'($urandom), $urandom, rd_d, wr_d,
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), mode);
    end
    do_txn(1,0,0,0, 5'd0, 32'h0BAD_F00D, 0, 12'h305, 32'h1357_9BDF, 0,NOACK, 0,0, 3);
    do_txn(0,1,0,1, 5'd4, 32'h0,         0, 12'h300, 32'h0000_0001, 0,0, 0,0, 0);
    repeat (5) @(negedge CLK);
    check("pending_results", 32'(exp_q.size()), 32'd0);
    check("pending_writes", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
